rd_control: RTL and testbench

Read-back control FSM for the UART configuration link, complementary to the write path. On a read request it parallel-loads the configuration registers into the TX byte shift chain, then hands bytes one at a time to the UART transmitter with a ready/start handshake, shifting the chain between bytes. After the last byte it pulses `done_rd`. It sits between the top-level command decoder (`start_rd`), the UART TX (`txrdy`, `tx_start`) and the TX register chain (`load_txregs`, `shift_txregs`).

---
 rtl/rd_control_pkg.sv | 28 ++
 rtl/rd_control.sv | 110 +++++++++++
 tb/tb_rd_control.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_control_pkg.sv
// Shared definitions for the UART configuration link read-back path:
// state encodings, LED codes and frame size shared with the write path and register chains.
package rd_control_pkg;

  localparam int N_BYTES_DEF = 10;
  localparam int CW_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_SHIFT     = 3'd6,
    ST_DONE      = 3'd7
  } rd_state_e;

  localparam logic [2:0] LEDS_IDLE     = 3'b001;
  localparam logic [2:0] LEDS_LOAD     = 3'b100;
  localparam logic [2:0] LEDS_WAIT_RDY = 3'b101;
  localparam logic [2:0] LEDS_SEND     = 3'b010;
  localparam logic [2:0] LEDS_WAIT_TX  = 3'b110;
  localparam logic [2:0] LEDS_SHIFT    = 3'b011;
  localparam logic [2:0] LEDS_DONE     = 3'b111;
  localparam logic [2:0] LEDS_INVALID  = 3'b000;

endpackage

// File: rtl/rd_control.sv
// Read-back control FSM: loads the config registers into the TX chain and streams
// N_BYTES bytes to the UART transmitter with a ready/start handshake.
module rd_control
  import rd_control_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_rd,
  input  logic       txrdy,
  output logic       tx_start,
  output logic       load_txregs,
  output logic       shift_txregs,
  output logic       done_rd,
  output logic [2:0] rd_leds
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

  rd_state_e     state_r;
  rd_state_e     next_state_s;
  logic [CW-1:0] count_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Byte counter: cleared on load, advanced once per chain shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case (state_r)
        ST_LOAD:  count_r <= '0;
        ST_SHIFT: count_r <= count_r + CW'(1);
        default:  count_r <= count_r;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_rd) next_state_s = ST_LOAD;
        else          next_state_s = ST_IDLE;
      end
      ST_LOAD:     next_state_s = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (txrdy) next_state_s = ST_SEND;
        else       next_state_s = ST_WAIT_RDY;
      end
      ST_SEND:     next_state_s = ST_WAIT_BUSY;
      // Wait for the UART to acknowledge the byte by dropping ready
      ST_WAIT_BUSY: begin
        if (!txrdy) next_state_s = ST_WAIT_DONE;
        else        next_state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (!txrdy)                  next_state_s = ST_WAIT_DONE;
        else if (count_r == LAST_IDX) next_state_s = ST_DONE;
        else                         next_state_s = ST_SHIFT;
      end
      ST_SHIFT:    next_state_s = ST_WAIT_RDY;
      ST_DONE:     next_state_s = ST_IDLE;
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    tx_start     = 1'b0;
    load_txregs  = 1'b0;
    shift_txregs = 1'b0;
    done_rd      = 1'b0;
    rd_leds      = LEDS_INVALID;
    case (state_r)
      ST_IDLE:      rd_leds = LEDS_IDLE;
      ST_LOAD: begin
        rd_leds     = LEDS_LOAD;
        load_txregs = 1'b1;
      end
      ST_WAIT_RDY:  rd_leds = LEDS_WAIT_RDY;
      ST_SEND: begin
        rd_leds  = LEDS_SEND;
        tx_start = 1'b1;
      end
      ST_WAIT_BUSY: rd_leds = LEDS_WAIT_TX;
      ST_WAIT_DONE: rd_leds = LEDS_WAIT_TX;
      ST_SHIFT: begin
        rd_leds      = LEDS_SHIFT;
        shift_txregs = 1'b1;
      end
      ST_DONE: begin
        rd_leds = LEDS_DONE;
        done_rd = 1'b1;
      end
      default: rd_leds = LEDS_INVALID;
    endcase
  end

endmodule

// File: tb/tb_rd_control.sv
// Directed self-checking bench for rd_control with a simple UART TX busy-time model.
module tb_rd_control;

  logic       clk;
  logic       rst_n;
  logic       start_rd;
  logic       txrdy;
  logic       tx_start;
  logic       load_txregs;
  logic       shift_txregs;
  logic       done_rd;
  logic [2:0] rd_leds;

  int  n_checks;
  int  n_errors;
  int  n_load, n_start, n_shift, n_done;
  byte log_q[$];
  bit  uart_en;
  int  busy;

  rd_control #(.N_BYTES(10), .CW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_rd     (start_rd),
    .txrdy        (txrdy),
    .tx_start     (tx_start),
    .load_txregs  (load_txregs),
    .shift_txregs (shift_txregs),
    .done_rd      (done_rd),
    .rd_leds      (rd_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (load_txregs)  begin n_load++;  log_q.push_back(8'h4C); end
    if (tx_start)     begin n_start++; log_q.push_back(8'h53); end
    if (shift_txregs) begin n_shift++; log_q.push_back(8'h48); end
    if (done_rd)      begin n_done++;  log_q.push_back(8'h44); end
  end

  // UART model: ready drops for 20 cycles after each tx_start
  always @(negedge clk) begin
    if (uart_en) begin
      if (tx_start) begin
        busy  = 20;
        txrdy = 1'b0;
      end else if (busy > 0) begin
        busy = busy - 1;
        if (busy == 0) txrdy = 1'b1;
      end
    end
  end

  task automatic clear_log();
    n_load = 0; n_start = 0; n_shift = 0; n_done = 0;
    log_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start_rd = 1'b1;
    @(negedge clk) start_rd = 1'b0;
  endtask

  task automatic wait_done_count(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (n_done < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (n_done < target) begin
      n_errors++;
      $display("FAIL wait_done timeout: done count %0d, required %0d", n_done, target);
    end
  endtask

  task automatic wait_start_count(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (n_start < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (n_start < target) begin
      n_errors++;
      $display("FAIL wait_start timeout: tx_start count %0d, required %0d", n_start, target);
    end
  endtask

  task automatic test_reset();
    uart_en = 1'b0;
    txrdy   = 1'b0;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (rd_leds !== 3'b101) begin
      n_errors++; $display("FAIL reset_pre_leds: got %b, required 101", rd_leds);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_leds !== 3'b001) begin
      n_errors++; $display("FAIL reset_async_leds: got %b, required 001", rd_leds);
    end
    n_checks++;
    if ({tx_start, load_txregs, shift_txregs, done_rd} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_async_pulses: got %b, required 0000",
               {tx_start, load_txregs, shift_txregs, done_rd});
    end
    @(negedge clk) begin rst_n = 1'b1; txrdy = 1'b1; end
    clear_log();
    repeat (4) @(negedge clk);
    n_checks++;
    if (rd_leds !== 3'b001 || n_load !== 0) begin
      n_errors++; $display("FAIL reset_stay_idle: leds %b loads %0d, required 001 and 0", rd_leds, n_load);
    end
  endtask

  task automatic test_full_frame();
    byte exp_q[$];
    int  bad;
    clear_log();
    uart_en = 1'b1;
    txrdy   = 1'b1;
    @(negedge clk) start_rd = 1'b1;
    @(negedge clk) start_rd = 1'b0;
    n_checks++;
    if (load_txregs !== 1'b1) begin
      n_errors++; $display("FAIL frame_load_latency: load_txregs %b, required 1", load_txregs);
    end
    @(negedge clk);
    n_checks++;
    if (rd_leds !== 3'b101) begin
      n_errors++; $display("FAIL frame_wait_rdy_leds: got %b, required 101", rd_leds);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || rd_leds !== 3'b010) begin
      n_errors++; $display("FAIL frame_first_send: tx_start %b leds %b, required 1 010", tx_start, rd_leds);
    end
    wait_done_count(1, 3000);
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_load !== 1 || n_start !== 10 || n_shift !== 9 || n_done !== 1) begin
      n_errors++;
      $display("FAIL frame_counts: L%0d S%0d H%0d D%0d, required L1 S10 H9 D1",
               n_load, n_start, n_shift, n_done);
    end
    exp_q.push_back(8'h4C);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(8'h53);
      exp_q.push_back(8'h48);
    end
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h44);
    bad = 0;
    if (log_q.size() != exp_q.size()) bad = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (log_q[i] != exp_q[i]) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL frame_order: %0d events logged, required 21 in order L(SH)x9 S D", log_q.size());
    end
    n_checks++;
    if (rd_leds !== 3'b001) begin
      n_errors++; $display("FAIL frame_end_idle: leds %b, required 001", rd_leds);
    end
  endtask

  task automatic test_ignore_start();
    clear_log();
    uart_en = 1'b1;
    pulse_start();
    wait_start_count(3, 1000);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rd_leds !== 3'b110) begin
      n_errors++; $display("FAIL ignore_in_wait_done: leds %b, required 110", rd_leds);
    end
    pulse_start();
    wait_done_count(1, 3000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_load !== 1 || n_start !== 10 || n_done !== 1 || rd_leds !== 3'b001) begin
      n_errors++;
      $display("FAIL ignore_counts: L%0d S%0d D%0d leds %b, required L1 S10 D1 001",
               n_load, n_start, n_done, rd_leds);
    end
  endtask

  task automatic test_wait_rdy();
    clear_log();
    uart_en = 1'b0;
    txrdy   = 1'b0;
    pulse_start();
    repeat (15) @(negedge clk);
    n_checks++;
    if (rd_leds !== 3'b101 || n_start !== 0) begin
      n_errors++; $display("FAIL wait_rdy_hold: leds %b starts %0d, required 101 and 0", rd_leds, n_start);
    end
    txrdy   = 1'b1;
    uart_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1) begin
      n_errors++; $display("FAIL wait_rdy_release: tx_start %b, required 1", tx_start);
    end
    wait_done_count(1, 3000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_start !== 10 || n_shift !== 9 || n_done !== 1) begin
      n_errors++; $display("FAIL wait_rdy_counts: S%0d H%0d D%0d, required S10 H9 D1", n_start, n_shift, n_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    uart_en = 1'b1;
    pulse_start();
    wait_start_count(5, 1000);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_leds !== 3'b001 || done_rd !== 1'b0) begin
      n_errors++; $display("FAIL midreset_async: leds %b done %b, required 001 0", rd_leds, done_rd);
    end
    uart_en = 1'b0;
    busy    = 0;
    txrdy   = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_done !== 0) begin
      n_errors++; $display("FAIL midreset_no_done: done count %0d, required 0", n_done);
    end
    clear_log();
    uart_en = 1'b1;
    @(negedge clk) start_rd = 1'b1;
    @(negedge clk) start_rd = 1'b0;
    n_checks++;
    if (load_txregs !== 1'b1) begin
      n_errors++; $display("FAIL midreset_reload: load_txregs %b, required 1", load_txregs);
    end
    wait_done_count(1, 3000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_load !== 1 || n_start !== 10 || n_shift !== 9 || n_done !== 1) begin
      n_errors++;
      $display("FAIL midreset_frame: L%0d S%0d H%0d D%0d, required L1 S10 H9 D1",
               n_load, n_start, n_shift, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_log();
    uart_en = 1'b1;
    @(negedge clk) start_rd = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cyc = 0;
      @(negedge clk);
      while (done_rd !== 1'b1 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (done_rd !== 1'b1) begin
        n_errors++; $display("FAIL b2b_done_timeout: frame %0d no done_rd", f);
      end
      @(negedge clk);
      n_checks++;
      if (rd_leds !== 3'b001) begin
        n_errors++; $display("FAIL b2b_idle_after_done: leds %b, required 001", rd_leds);
      end
      @(negedge clk);
      n_checks++;
      if (load_txregs !== 1'b1) begin
        n_errors++; $display("FAIL b2b_retrigger: load_txregs %b, required 1", load_txregs);
      end
    end
    start_rd = 1'b0;
    wait_done_count(3, 3000);
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_load !== 3 || n_start !== 30 || n_shift !== 27 || n_done !== 3 || rd_leds !== 3'b001) begin
      n_errors++;
      $display("FAIL b2b_counts: L%0d S%0d H%0d D%0d leds %b, required L3 S30 H27 D3 001",
               n_load, n_start, n_shift, n_done, rd_leds);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    uart_en  = 1'b0;
    busy     = 0;
    rst_n    = 1'b0;
    start_rd = 1'b0;
    txrdy    = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_frame();
    test_ignore_start();
    test_wait_rdy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
